// File: rtl/drink_pkg.sv
// Shared definitions for the drink sequencer: the 4-bit state encoding
// and a helper used to size the seconds counter.
package drink_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEL_ADD   = 4'd1,
    ST_DISP_BASE = 4'd2,
    ST_DISP_ADD  = 4'd3,
    ST_DONE      = 4'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Prescaler plus seconds counter shared by every timed phase.
// Ports:
//   CLK, RESET  clock, synchronous active-high reset
//   clear       zero both counters this edge
//   term        seconds value (T-1) on which the phase ends
//   expired     high on the last cycle of the phase
module sec_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SEC_W    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic [SEC_W-1:0] term,
  output logic             expired
);

  localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEC_W-1:0] sec_q, sec_d;

  always_comb begin
    pre_d = pre_q + 1'b1;
    sec_d = sec_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      sec_d = sec_q + 1'b1;
    end
    if (clear) begin
      pre_d = '0;
      sec_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q <= '0;
      sec_q <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
    end
  end

  assign expired = (pre_q == PRE_LAST) && (sec_q == term);

endmodule

// File: rtl/drink_sequencer.sv
// Beverage-dispenser sequencer: picks a base drink and optional additive
// by lowest-index priority, then times each valve phase in seconds.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   base_req     base-drink buttons (level)
//   add_req      additive buttons (level)
//   none_req     "no additive" button
//   state_cur    registered state
//   state_nxt    combinational next state
//   base_valve   one-hot base valve drive
//   add_valve    one-hot additive valve drive
//   busy         high outside IDLE
//   done         one-cycle completion pulse
module drink_sequencer
  import drink_pkg::*;
#(
  parameter int unsigned N_BASE   = 2,
  parameter int unsigned N_ADD    = 2,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_BASE   = 5,
  parameter int unsigned T_ADD    = 3,
  parameter int unsigned T_SEL    = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_BASE-1:0] base_req,
  input  logic [N_ADD-1:0]  add_req,
  input  logic              none_req,
  output logic [3:0]        state_cur,
  output logic [3:0]        state_nxt,
  output logic [N_BASE-1:0] base_valve,
  output logic [N_ADD-1:0]  add_valve,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BW    = (N_BASE > 1) ? $clog2(N_BASE) : 1;
  localparam int unsigned AW    = (N_ADD > 1) ? $clog2(N_ADD) : 1;
  localparam int unsigned SEC_W = $clog2(max3(T_BASE, T_ADD, T_SEL) + 1);

  state_e         state_q, state_d;
  logic           armed_q, armed_d;
  logic [BW-1:0]  sel_base_q, sel_base_d;
  logic [AW-1:0]  sel_add_q, sel_add_d;
  logic           use_add_q, use_add_d;

  logic [BW-1:0]    base_idx;
  logic [AW-1:0]    add_idx;
  logic             base_hit, add_hit;
  logic             tmr_clear, tmr_expired;
  logic [SEC_W-1:0] tmr_term;

  // Lowest set index wins for simultaneous presses.
  always_comb begin
    base_idx = '0;
    base_hit = 1'b0;
    for (int unsigned i = 0; i < N_BASE; i++) begin
      if (base_req[i] && !base_hit) begin
        base_idx = BW'(i);
        base_hit = 1'b1;
      end
    end
    add_idx = '0;
    add_hit = 1'b0;
    for (int unsigned i = 0; i < N_ADD; i++) begin
      if (add_req[i] && !add_hit) begin
        add_idx = AW'(i);
        add_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | (base_req == '0);
    sel_base_d = sel_base_q;
    sel_add_d  = sel_add_q;
    use_add_d  = use_add_q;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && base_hit) begin
          sel_base_d = base_idx;
          armed_d    = 1'b0;
          state_d    = ST_SEL_ADD;
        end
      end
      ST_SEL_ADD: begin
        // A button on the final timeout cycle beats the timeout.
        if (none_req) begin
          use_add_d = 1'b0;
          state_d   = ST_DISP_BASE;
        end else if (add_hit) begin
          sel_add_d = add_idx;
          use_add_d = 1'b1;
          state_d   = ST_DISP_BASE;
        end else if (tmr_expired) begin
          use_add_d = 1'b0;
          state_d   = ST_DISP_BASE;
        end
      end
      ST_DISP_BASE: begin
        if (tmr_expired) state_d = use_add_q ? ST_DISP_ADD : ST_DONE;
      end
      ST_DISP_ADD: begin
        if (tmr_expired) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (RESET) state_d = ST_IDLE;
  end

  // Timer restarts on every state change and idles cleared outside timed
  // phases, so the seconds counter never wraps.
  always_comb begin
    tmr_term  = '0;
    tmr_clear = RESET || (state_d != state_q);
    case (state_q)
      ST_SEL_ADD:   tmr_term = SEC_W'(T_SEL - 1);
      ST_DISP_BASE: tmr_term = SEC_W'(T_BASE - 1);
      ST_DISP_ADD:  tmr_term = SEC_W'(T_ADD - 1);
      default:      tmr_clear = 1'b1;
    endcase
  end

  sec_timer #(
    .TICK_DIV (TICK_DIV),
    .SEC_W    (SEC_W)
  ) u_sec_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (tmr_clear),
    .term    (tmr_term),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b1;
      sel_base_q <= '0;
      sel_add_q  <= '0;
      use_add_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      sel_base_q <= sel_base_d;
      sel_add_q  <= sel_add_d;
      use_add_q  <= use_add_d;
    end
  end

  always_comb begin
    state_cur  = state_q;
    state_nxt  = state_d;
    base_valve = '0;
    add_valve  = '0;
    if (state_q == ST_DISP_BASE) base_valve = N_BASE'(1) << sel_base_q;
    if (state_q == ST_DISP_ADD)  add_valve  = N_ADD'(1) << sel_add_q;
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_drink_sequencer.sv
module tb_drink_sequencer;

  localparam int TD = 4;
  localparam int TB = 3;
  localparam int TA = 2;
  localparam int TS = 5;

  logic       clk = 1'b0;
  logic       RESET;
  logic [1:0] base_req, add_req;
  logic       none_req;
  logic [3:0] state_cur, state_nxt;
  logic [1:0] base_valve, add_valve;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase code plus a countdown of cycles left in phase.
  int m_state, m_rem, m_sb, m_sa, m_ua, m_armed;
  int cnt_base, cnt_add, cnt_done;

  always #5 clk = ~clk;

  drink_sequencer #(
    .N_BASE   (2),
    .N_ADD    (2),
    .TICK_DIV (TD),
    .T_BASE   (TB),
    .T_ADD    (TA),
    .T_SEL    (TS)
  ) dut (
    .CLK        (clk),
    .RESET      (RESET),
    .base_req   (base_req),
    .add_req    (add_req),
    .none_req   (none_req),
    .state_cur  (state_cur),
    .state_nxt  (state_nxt),
    .base_valve (base_valve),
    .add_valve  (add_valve),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [1:0] v);
    for (int i = 0; i < 2; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int phase_len(input int s);
    case (s)
      1: return TS * TD;
      2: return TB * TD;
      3: return TA * TD;
      default: return 0;
    endcase
  endfunction

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic step(input logic rst, input logic [1:0] b, input logic [1:0] a, input logic n);
    int ns, nrem, nsb, nsa, nua, narm;
    RESET = rst; base_req = b; add_req = a; none_req = n;
    #4;
    ns = m_state; nrem = m_rem - 1; nsb = m_sb; nsa = m_sa; nua = m_ua;
    narm = (m_armed != 0 || b == 2'b00) ? 1 : 0;
    case (m_state)
      0: if (m_armed != 0 && b != 2'b00) begin nsb = lowest(b); narm = 0; ns = 1; end
      1: begin
        if (n) begin nua = 0; ns = 2; end
        else if (a != 2'b00) begin nsa = lowest(a); nua = 1; ns = 2; end
        else if (m_rem == 1) begin nua = 0; ns = 2; end
      end
      2: if (m_rem == 1) ns = (m_ua != 0) ? 3 : 4;
      3: if (m_rem == 1) ns = 4;
      default: ns = 0;
    endcase
    if (rst) begin ns = 0; nsb = 0; nsa = 0; nua = 0; narm = 1; end
    if (ns != m_state) nrem = phase_len(ns);

    check("state_cur", state_cur, m_state);
    check("state_nxt", state_nxt, ns);
    check("base_valve", base_valve, (m_state == 2) ? (1 << m_sb) : 0);
    check("add_valve", add_valve, (m_state == 3) ? (1 << m_sa) : 0);
    check("busy", busy, (m_state != 0) ? 1 : 0);
    check("done", done, (m_state == 4) ? 1 : 0);
    if (base_valve != 2'b00) cnt_base++;
    if (add_valve != 2'b00) cnt_add++;
    if (done) cnt_done++;

    @(posedge clk);
    m_state = ns; m_rem = nrem; m_sb = nsb; m_sa = nsa; m_ua = nua; m_armed = narm;
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic clr_counts;
    cnt_base = 0; cnt_add = 0; cnt_done = 0;
  endtask

  initial begin
    RESET = 1'b1; base_req = '0; add_req = '0; none_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_state = 0; m_rem = 0; m_sb = 0; m_sa = 0; m_ua = 0; m_armed = 1;

    // Reset state
    step(1'b1, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 1'b0);
    check("rst_state", state_cur, 4'd0);
    check("rst_nxt", state_nxt, 4'd0);

    // Full cycle with additive: coffee wins, water selected
    clr_counts();
    step(1'b0, 2'b11, 2'b00, 1'b0);
    check("busy_latency", busy, 1'b1);
    step(1'b0, 2'b00, 2'b10, 1'b0);
    idle(25);
    check("full_base_len", cnt_base, 12);
    check("full_add_len", cnt_add, 8);
    check("full_done_len", cnt_done, 1);

    // none_req beats add_req
    clr_counts();
    step(1'b0, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b01, 1'b1);
    idle(20);
    check("none_base_len", cnt_base, 12);
    check("none_add_len", cnt_add, 0);
    check("none_done_len", cnt_done, 1);

    // Selection timeout after 20 cycles
    step(1'b0, 2'b10, 2'b00, 1'b0);
    idle(20);
    check("tmo_state", state_cur, 4'd2);
    check("tmo_valve", base_valve, 2'b10);
    idle(15);

    // Press on the final timeout cycle wins
    clr_counts();
    step(1'b0, 2'b10, 2'b00, 1'b0);
    idle(19);
    step(1'b0, 2'b00, 2'b01, 1'b0);
    idle(25);
    check("tmo_edge_add_len", cnt_add, 8);

    // Reset on 5th cycle of DISP_BASE
    step(1'b0, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1);
    idle(4);
    clr_counts();
    step(1'b1, 2'b00, 2'b00, 1'b0);
    check("midrst_state", state_cur, 4'd0);
    check("midrst_valve", base_valve, 2'b00);
    idle(10);
    check("midrst_done", cnt_done, 0);

    // Held button does not restart
    step(1'b0, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 2'b01, 2'b00, 1'b0);
    check("held_idle", state_cur, 4'd0);
    step(1'b0, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b01, 2'b00, 1'b0);
    check("rearm_sel", state_cur, 4'd1);
    step(1'b0, 2'b00, 2'b00, 1'b1);
    idle(15);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic       r, n;
      logic [1:0] b, a;
      r = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      a = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      n = ($urandom_range(0, 23) == 0);
      step(r, b, a, n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drink_sequencer.md
# drink_sequencer

Parametrised beverage-dispenser sequencer for the vending FSM project: the successor to the fixed coffee/tea/milk/water/vanilla selector. It accepts N_BASE base-drink buttons and N_ADD additive buttons, resolves simultaneous presses by fixed priority, and times each dispense phase in seconds from a single system clock through an internal prescaler, replacing the separate seconds clock. It drives one valve per channel and exposes the current and next state for the display/debug logic, as the earlier selector did.

## Interface

Parameters:
- N_BASE, 2: number of base-drink channels (index 0 = coffee, 1 = tea, …)
- N_ADD, 2: number of additive channels (index 0 = milk, 1 = water, …)
- TICK_DIV, 50_000_000: CLK cycles per second; must be ≥ 2
- T_BASE, 5: base dispense time in seconds; must be ≥ 1
- T_ADD, 3: additive dispense time in seconds; must be ≥ 1
- T_SEL, 10: additive-selection timeout in seconds; must be ≥ 1

Ports:
- CLK  in  1  system clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- base_req  in  N_BASE  base-drink buttons, level-sensitive
- add_req  in  N_ADD  additive buttons, level-sensitive
- none_req  in  1  "no additive" button
- state_cur  out  4  registered current state
- state_nxt  out  4  combinational next state
- base_valve  out  N_BASE  one-hot base valve drive
- add_valve  out  N_ADD  one-hot additive valve drive
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion

## Operation

State encodings are IDLE=0, SEL_ADD=1, DISP_BASE=2, DISP_ADD=3, DONE=4. Codes 5–15 are illegal and go to IDLE on the next cycle.

- **IDLE:** A press is accepted only when armed. `armed` is cleared on acceptance and set on any cycle where base_req == 0.
  - If armed and any base_req bit is set: latch `sel_base` as the lowest set index and go to SEL_ADD.
- **SEL_ADD:**
  - none_req=1: set `use_add`=0 and go to DISP_BASE. none_req wins over add_req when both are set in the same cycle.
  - Otherwise, any add_req bit set: latch `sel_add` as the lowest set index, set `use_add`=1, and go to DISP_BASE.
  - Timeout of T_SEL seconds with no input: set `use_add`=0 and go to DISP_BASE.
- **DISP_BASE:** base_valve[sel_base]=1 for exactly T_BASE seconds, then go to DISP_ADD if `use_add`, else go to DONE.
- **DISP_ADD:** add_valve[sel_add]=1 for exactly T_ADD seconds, then go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE.
- All buttons are ignored outside IDLE and SEL_ADD. A button still held after DONE does not restart a cycle because `armed` is still clear.
- **Outputs:** every output is decoded from state_cur, sel_base, sel_add and use_add only (Moore). Outputs never depend combinationally on the inputs, except state_nxt.
- **Reset values:** state_cur=0, base_valve=0, add_valve=0, busy=0, done=0, armed=1, sel_base=0, sel_add=0, use_add=0.

## Timing

- Each timed phase lasts exactly T×TICK_DIV cycles, measured from the cycle state_cur enters the phase.
  - The prescaler and seconds counter both clear on every state change.
  - The phase exits on the cycle where the seconds count equals T−1 and the prescaler equals TICK_DIV−1.
- The SEL_ADD timeout is T_SEL×TICK_DIV cycles. A valid button press in the final timeout cycle takes precedence over the timeout.
- There is one cycle of latency from a base_req press, sampled at an edge, to busy=1.
- Valve-to-valve handoff is gapless: base_valve falls on the same edge add_valve rises.
- RESET in any state returns to IDLE at the next edge. All valves go low and done is not pulsed.
- Counter widths: $clog2(TICK_DIV) for the prescaler and $clog2(max(T_BASE,T_ADD,T_SEL)+1) for the seconds counter. Neither counter may wrap inside a phase.

## Structure

- **Package `drink_pkg`:** the 4-bit state typedef and encodings, and a `max3` function for sizing the seconds counter.
- **Sub-module `sec_timer`:** prescaler plus seconds counter. Its ports are clear, a terminal-count input, and an `expired` output. The top level instantiates it once and shares it across all timed states.
- **Top level:** the state register, next-state logic, selection latches, `armed` flag and output decode.

## Test plan

Use TICK_DIV=4, T_BASE=3, T_ADD=2, T_SEL=5, N_BASE=2, N_ADD=2.

- **Reset state:** hold RESET for 2 cycles → all outputs 0, state_cur=0, state_nxt=0.
- **Full cycle with additive:** base_req=2'b11 for one cycle, then add_req=2'b10 → sel_base=0. Expect base_valve=2'b01 for exactly 12 cycles, then add_valve=2'b10 for exactly 8 cycles, then done for 1 cycle, then IDLE.
- **none_req precedence:** none_req=1 and add_req=2'b01 in the same cycle → no add_valve activity, and DONE directly after 12 cycles of base dispense.
- **Selection timeout:** select tea, then give no input for 20 cycles → DISP_BASE with base_valve=2'b10. A press of add_req on cycle 20 instead selects the additive.
- **Reset mid-dispense:** assert RESET on the 5th cycle of DISP_BASE → next edge shows state_cur=0 and valves 0, with no done pulse.
- **Held button:** hold base_req=2'b01 through DONE → stays in IDLE. Release for 1 cycle, then press again → SEL_ADD.
